if_stage: RTL and testbench

- Instruction-fetch stage inside the AHU_LA2023 core.
- Sits directly upstream of the instruction ROM and decode.
- Owns the PC and drives the ROM address and chip-enable; the ROM reads combinationally, so the instruction returns in the same cycle.
- Registers {pc, inst} into an IF/ID valid/ready pipeline register, with branch redirect, decode back-pressure, and fetch-address-error (ADEF) tagging.

---
 rtl/if_stage.sv | 79 +++++++
 tb/tb_if_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational ROM, and registers
// {pc, inst} into the IF/ID valid/ready register with redirect and ADEF tagging.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter logic [31:0] NOP_INST = 32'h0340_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              rom_ce_o,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [31:0]       id_inst_o,
  output logic              id_adef_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [31:0]       id_inst_q, id_inst_d;
  logic              id_adef_q, id_adef_d;
  logic              adv, redirect, misal;

  assign misal    = pc_q[1:0] != 2'b00;
  assign redirect = ce_q & br_taken_i;
  assign adv      = ce_q & (~vld_q | id_ready_i) & ~br_taken_i;

  always_comb begin
    pc_d      = pc_q;
    ce_d      = 1'b1;
    vld_d     = vld_q;
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    id_adef_d = id_adef_q;
    // Redirect wins over stall: the wrong-path entry is dropped even if decode is stalled.
    if (redirect) begin
      pc_d  = br_target_i;
      vld_d = 1'b0;
    end else if (adv) begin
      pc_d      = pc_q + ADDR_W'(4);
      vld_d     = 1'b1;
      id_pc_d   = pc_q;
      id_adef_d = misal;
      id_inst_d = misal ? NOP_INST : inst_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC[ADDR_W-1:0];
      ce_q      <= 1'b0;
      vld_q     <= 1'b0;
      id_pc_q   <= '0;
      id_inst_q <= '0;
      id_adef_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ce_q      <= ce_d;
      vld_q     <= vld_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_adef_q <= id_adef_d;
    end
  end

  assign inst_addr_o = pc_q;
  assign rom_ce_o    = ce_q;
  assign id_valid_o  = vld_q;
  assign id_pc_o     = id_pc_q;
  assign id_inst_o   = id_inst_q;
  assign id_adef_o   = id_adef_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, stall, redirect, ADEF, async reset, PC wrap.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_o;
  logic        rom_ce_o;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_adef_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign inst_i = rom(inst_addr_o);

  if_stage dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_o(inst_addr_o),
    .rom_ce_o(rom_ce_o), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .id_ready_i(id_ready_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_adef_o(id_adef_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ce"},   32'(rom_ce_o),   32'd0);
    chk({tag, ".vld"},  32'(id_valid_o), 32'd0);
    chk({tag, ".addr"}, inst_addr_o,     32'h1c00_0000);
    chk({tag, ".pc"},   id_pc_o,         32'h0);
    chk({tag, ".inst"}, id_inst_o,       32'h0);
    chk({tag, ".adef"}, 32'(id_adef_o),  32'd0);
  endtask

  initial begin
    rst = 1'b1; br_taken_i = 1'b0; br_target_i = '0; id_ready_i = 1'b1;
    step(); step();
    chk_reset("rst");

    // release: ce stays low this cycle, then first fetch
    rst = 1'b0;
    chk("rel.ce0", 32'(rom_ce_o), 32'd0);
    step();
    chk("rel.ce1",  32'(rom_ce_o),   32'd1);
    chk("rel.addr", inst_addr_o,     32'h1c00_0000);
    chk("rel.vld0", 32'(id_valid_o), 32'd0);
    step();
    chk("f0.addr", inst_addr_o,     32'h1c00_0004);
    chk("f0.vld",  32'(id_valid_o), 32'd1);
    chk("f0.pc",   id_pc_o,         32'h1c00_0000);
    chk("f0.inst", id_inst_o,       rom(32'h1c00_0000));
    step();
    chk("f1.pc",   id_pc_o,     32'h1c00_0004);
    chk("f1.addr", inst_addr_o, 32'h1c00_0008);

    // stall three cycles
    id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl.pc",   id_pc_o,         32'h1c00_0004);
      chk("stl.inst", id_inst_o,       rom(32'h1c00_0004));
      chk("stl.addr", inst_addr_o,     32'h1c00_0008);
      chk("stl.vld",  32'(id_valid_o), 32'd1);
    end
    id_ready_i = 1'b1;
    step();
    chk("drn.pc",   id_pc_o,     32'h1c00_0008);
    chk("drn.inst", id_inst_o,   rom(32'h1c00_0008));
    chk("drn.addr", inst_addr_o, 32'h1c00_000c);

    // redirect while stalled
    id_ready_i = 1'b0;
    step();
    chk("stl2.pc", id_pc_o, 32'h1c00_0008);
    br_taken_i = 1'b1; br_target_i = 32'h1c00_0100;
    step();
    chk("br.vld",  32'(id_valid_o), 32'd0);
    chk("br.addr", inst_addr_o,     32'h1c00_0100);
    br_taken_i = 1'b0;
    step();
    chk("br2.vld",  32'(id_valid_o), 32'd1);
    chk("br2.pc",   id_pc_o,         32'h1c00_0100);
    chk("br2.inst", id_inst_o,       rom(32'h1c00_0100));
    chk("br2.addr", inst_addr_o,     32'h1c00_0104);

    // misaligned redirect -> ADEF
    id_ready_i = 1'b1;
    br_taken_i = 1'b1; br_target_i = 32'h1c00_0102;
    step();
    chk("ad.vld0", 32'(id_valid_o), 32'd0);
    chk("ad.addr", inst_addr_o,     32'h1c00_0102);
    br_taken_i = 1'b0;
    step();
    chk("ad.vld",   32'(id_valid_o), 32'd1);
    chk("ad.adef",  32'(id_adef_o),  32'd1);
    chk("ad.inst",  id_inst_o,       32'h0340_0000);
    chk("ad.pc",    id_pc_o,         32'h1c00_0102);
    chk("ad.naddr", inst_addr_o,     32'h1c00_0106);

    // async reset mid-stall, checked before the next edge
    id_ready_i = 1'b0;
    step();
    #2 rst = 1'b1;
    #1 chk_reset("arst");

    // release with a redirect in the ce=0 cycle: must be ignored
    step();
    rst = 1'b0; id_ready_i = 1'b1;
    br_taken_i = 1'b1; br_target_i = 32'h1c00_0200;
    step();
    chk("ign.ce",   32'(rom_ce_o), 32'd1);
    chk("ign.addr", inst_addr_o,   32'h1c00_0000);
    br_taken_i = 1'b0;
    step();
    chk("ign.pc",   id_pc_o,       32'h1c00_0000);
    chk("ign.adef", 32'(id_adef_o), 32'd0);

    // PC wrap
    br_taken_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
    step();
    chk("wr.addr", inst_addr_o, 32'hFFFF_FFFC);
    br_taken_i = 1'b0;
    step();
    chk("wr.pc",   id_pc_o,     32'hFFFF_FFFC);
    chk("wr.inst", id_inst_o,   rom(32'hFFFF_FFFC));
    chk("wr.addr0", inst_addr_o, 32'h0);
    step();
    chk("wr.pc0",  id_pc_o,     32'h0);
    chk("wr.addr4", inst_addr_o, 32'h4);
    chk("wr.nox", 32'($isunknown({inst_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o, id_adef_o})), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
